// File: rtl/seq_matrix_alu_pkg.sv
// seq_matrix_alu_pkg: opcodes, FSM states and width helpers shared by the matrix ALU
package seq_matrix_alu_pkg;
    typedef enum logic [2:0] {
        OP_MATMUL    = 3'd0,
        OP_SCALE     = 3'd1,
        OP_ADD       = 3'd2,
        OP_SUB       = 3'd3,
        OP_TRANSPOSE = 3'd4,
        OP_TRACE     = 3'd5
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_FIN} state_e;
    localparam logic [2:0] OP_LAST = 3'd5;
    function automatic int acc_w(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction
    function automatic int idx_w(input int n);
        return $clog2(n * n);
    endfunction
endpackage

// File: rtl/seq_matrix_alu_if.sv
// seq_matrix_alu_if: operand load, command and result stream signals of the matrix ALU
interface seq_matrix_alu_if
    import seq_matrix_alu_pkg::*;
#(
    parameter int N = 4,
    parameter int DATA_W = 16
) ();
    localparam int ACC_W = acc_w(N, DATA_W);
    localparam int AW = idx_w(N);
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_sel;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              start;
    logic [2:0]        op_sel;
    logic [DATA_W-1:0] alpha;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [AW-1:0]     res_addr;
    logic              res_last;
    logic              done;
    logic              err;
    modport slave (
        input  ld_valid, ld_sel, ld_addr, ld_data, start, op_sel, alpha, res_ready,
        output ld_ready, busy, res_valid, res_data, res_addr, res_last, done, err
    );
    modport master (
        output ld_valid, ld_sel, ld_addr, ld_data, start, op_sel, alpha, res_ready,
        input  ld_ready, busy, res_valid, res_data, res_addr, res_last, done, err
    );
endinterface

// File: rtl/matrix_regfile.sv
// matrix_regfile: NxN signed element store, one sync write port, two async read ports
module matrix_regfile
    import seq_matrix_alu_pkg::*;
#(
    parameter int N = 4,
    parameter int DATA_W = 16,
    localparam int AW = idx_w(N)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [AW-1:0]            raddr0_i,
    output logic signed [DATA_W-1:0] rdata0_o,
    input  logic [AW-1:0]            raddr1_i,
    output logic signed [DATA_W-1:0] rdata1_o
);
    logic signed [DATA_W-1:0] mem_q [N*N];

    // element storage, cleared as a whole by reset
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) for (int i = 0; i < N * N; i++) mem_q[i] <= '0;
        else if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];
endmodule

// File: rtl/seq_matrix_alu.sv
// seq_matrix_alu: sequential NxN matrix ALU with one shared MAC and a row-major result stream
module seq_matrix_alu
    import seq_matrix_alu_pkg::*;
#(
    parameter int N = 4,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_matrix_alu_if.slave bus
);
    localparam int ACC_W = acc_w(N, DATA_W);
    localparam int AW = idx_w(N);
    localparam int KW = $clog2(N);
    localparam int PW = 2 * DATA_W;

    state_e                   state_q, state_d;
    op_e                      op_q, op_d;
    logic signed [DATA_W-1:0] alpha_q, alpha_d, a0, a1, b0, b1;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d, calc;
    logic [AW-1:0]            e_q, e_d, ra0, ra1, rb1;
    logic [KW-1:0]            k_q, k_d;
    logic                     err_q, err_d, last, iter, busy, emit, ld_ok;
    int                       row, col;

    assign busy  = state_q == S_CALC || state_q == S_EMIT;
    assign emit  = state_q == S_EMIT;
    assign ld_ok = bus.ld_valid && !busy;

    matrix_regfile #(.N(N), .DATA_W(DATA_W)) u_a (
        .clk(clk), .reset_n(reset_n), .we_i(ld_ok && !bus.ld_sel), .waddr_i(bus.ld_addr),
        .wdata_i(bus.ld_data), .raddr0_i(ra0), .rdata0_o(a0), .raddr1_i(ra1), .rdata1_o(a1)
    );

    matrix_regfile #(.N(N), .DATA_W(DATA_W)) u_b (
        .clk(clk), .reset_n(reset_n), .we_i(ld_ok && bus.ld_sel), .waddr_i(bus.ld_addr),
        .wdata_i(bus.ld_data), .raddr0_i(e_q), .rdata0_o(b0), .raddr1_i(rb1), .rdata1_o(b1)
    );

    // operand addressing and the single shared multiply feeding the accumulator
    always_comb begin
        row  = int'(e_q) / N;
        col  = int'(e_q) % N;
        ra0  = op_q == OP_MATMUL ? AW'(row * N + int'(k_q))
             : op_q == OP_TRACE  ? AW'(int'(k_q) * (N + 1)) : e_q;
        ra1  = AW'(col * N + row);
        rb1  = AW'(int'(k_q) * N + col);
        iter = op_q == OP_MATMUL || op_q == OP_TRACE;
        last = op_q == OP_TRACE || e_q == AW'(N * N - 1);
        prod = PW'(a0) * PW'(op_q == OP_SCALE ? alpha_q : b1);
        calc = op_q == OP_MATMUL    ? acc_q + ACC_W'(prod)
             : op_q == OP_SCALE     ? ACC_W'(prod)
             : op_q == OP_ADD       ? ACC_W'(a0) + ACC_W'(b0)
             : op_q == OP_SUB       ? ACC_W'(a0) - ACC_W'(b0)
             : op_q == OP_TRANSPOSE ? ACC_W'(a1) : acc_q + ACC_W'(a0);
    end

    // command sequencing: capture, per-element compute, beat handshake, completion
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        alpha_d = alpha_q;
        e_d     = e_q;
        k_d     = k_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                if (bus.op_sel <= OP_LAST) begin
                    state_d = S_CALC;
                    op_d    = op_e'(bus.op_sel);
                    alpha_d = bus.alpha;
                    e_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end else err_d = 1'b1;
            end
            S_CALC: begin
                acc_d = calc;
                k_d   = k_q + KW'(1);
                if (!iter || k_q == KW'(N - 1)) begin
                    state_d = S_EMIT;
                    k_d     = '0;
                end
            end
            S_EMIT: if (bus.res_ready) begin
                if (last) state_d = S_FIN;
                else begin
                    state_d = S_CALC;
                    e_d     = e_q + AW'(1);
                    acc_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_MATMUL;
            alpha_q <= '0;
            e_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            alpha_q <= alpha_d;
            e_q     <= e_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end

    assign bus.ld_ready  = !busy;
    assign bus.busy      = busy;
    assign bus.res_valid = emit;
    assign bus.res_data  = emit ? acc_q : '0;
    assign bus.res_addr  = emit ? e_q : '0;
    assign bus.res_last  = emit && last;
    assign bus.done      = state_q == S_FIN;
    assign bus.err       = err_q;
endmodule

// File: doc/seq_matrix_alu.md
Name: seq_matrix_alu

Overview:
- Parametrised, sequential successor to the fixed 4x4 matrix ALU.
- Holds two NxN signed fixed-point operand matrices (A, B) loaded element-by-element.
- Executes one operation per start command and streams the result row-major over a valid/ready port.
- Sits between the IoT host register interface and downstream accumulation/storage logic; one shared MAC replaces the fully combinational arithmetic of the previous generation.

Parameters:
- N, 4: matrix dimension (NxN), N >= 2.
- DATA_W, 16: operand element width, signed two's complement.
- ACC_W, 2*DATA_W+$clog2(N): result width; every result is sign-extended to ACC_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  operand write strobe.
- ld_ready  out  1  high when writes are accepted (= !busy).
- ld_sel  in  1  0 = A buffer, 1 = B buffer.
- ld_addr  in  $clog2(N*N)  element index row*N+col.
- ld_data  in  DATA_W  element value.
- start  in  1  command strobe, sampled only in IDLE.
- op_sel  in  3  operation code, captured on start.
- alpha  in  DATA_W  scalar operand, captured on start.
- busy  out  1  high from the cycle after an accepted start until the final result handshake.
- res_valid  out  1  result beat valid.
- res_ready  in  1  downstream accepts beat.
- res_data  out  ACC_W  result value.
- res_addr  out  $clog2(N*N)  row-major index of the beat.
- res_last  out  1  final beat of the command.
- done  out  1  one-cycle pulse after the final beat handshake.
- err  out  1  one-cycle pulse on start with an illegal op_sel.

Behaviour:
- Reset (async assert, sync release): state IDLE; A, B, accumulator and counters cleared to 0; all outputs 0 except ld_ready=1. Reset mid-command aborts without emitting further beats.
- Opcodes:
  - 000 MATMUL: C = A*B.
  - 001 SCALE: C = A*alpha.
  - 010 ADD: C = A+B.
  - 011 SUB: C = A-B.
  - 100 TRANSPOSE: C[i][j] = A[j][i].
  - 101 TRACE: single scalar = sum of A[i][i].
  - 110, 111: illegal → err pulses the next cycle, state stays IDLE, no beats.
- Loads:
  - Accepted when ld_valid && ld_ready; written at that edge.
  - A load and a start in the same IDLE cycle: the load is written, and the command sees the new value.
  - ld_valid while busy is ignored.
- FSM states: IDLE, CALC, EMIT, FIN.
  - IDLE: on start with a legal op, capture op_sel/alpha, clear element index e=0 and k=0, go to CALC.
  - CALC:
    - MATMUL/TRACE: one MAC per cycle, k = 0..N-1; after the Nth cycle go to EMIT.
    - Elementwise ops: one cycle, then EMIT.
  - EMIT: res_valid=1; res_data/res_addr/res_last held stable until res_ready. On handshake:
    - If res_last, go to FIN.
    - Otherwise increment e, clear the accumulator, go to CALC.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Beat counts and latency:
  - Matrix ops emit N*N beats, addr 0..N*N-1; TRACE emits one beat, addr 0, res_last=1.
  - With res_ready held high, MATMUL costs N+1 cycles per element, elementwise ops 2 cycles per element, TRACE N+1 cycles.
  - First res_valid of an elementwise op appears 2 cycles after the start edge.
- Arithmetic: full-precision signed; no saturation and no rounding. ACC_W is sufficient for all ops at all N.
- start while busy is ignored; no queuing.

Decomposition:
- Package seq_matrix_alu_pkg:
  - opcode enum.
  - state enum.
  - ACC_W/index-width helper functions.
- One sub-module, matrix_regfile: NxN x DATA_W storage with one synchronous write port, two combinational read ports and async clear. It is instantiated twice (A, B).

Test Plan:
- N=4: A = identity, B[i][j] = 10*i+j, MATMUL with res_ready=1 → 16 beats, res_data = B row-major, res_last on addr 15, 5 cycles per beat, done pulse once.
- SCALE, alpha = -3, A[0][0] = 5, A[3][3] = -32768 → beat 0 = -15, beat 15 = 98304 (sign-extended ACC_W).
- TRACE, diag(A) = 1,2,3,4, off-diagonals 7 → one beat res_data = 10, res_addr = 0, res_last = 1, done the following cycle.
- TRANSPOSE with res_ready low for 5 cycles on beat 1 (A[0][1] = 3, A[1][0] = 9) → res_valid held, res_data stays 9 and stable, then resumes; ld_valid during busy leaves A unchanged.
- op_sel = 111 → err pulse one cycle, busy stays 0, no res_valid; a following legal start works normally.
- reset_n low during MATMUL beat 6 → all outputs 0 immediately, busy = 0, buffers read back 0 via TRACE = 0.
